stack_unit: RTL and testbench
=============================

// Module: stack_unit
// PURPOSE
//  Hardware data stack for the stack-processor datapath. It holds DEPTH words of
//  WIDTH bits and presents top-of-stack (tos) and next-of-stack (nos) to the ALU.
//  It is the read-back counterpart of the datapath registers: values are pushed
//  from the writeback bus and popped back as operands.
//  It tracks stack depth and raises sticky overflow and underflow error flags.
// PARAMETERS
//  WIDTH  16  data word width in bits
//  DEPTH  16  number of stack entries; must be a power of two, >= 2
//  AW     4   log2(DEPTH); sp is AW+1 bits wide so that it can hold the value DEPTH
// PORTS
//  clk        in   1        clock; all state updates on the falling edge (negedge)
//  reset      in   1        reset, synchronous, active-high
//  push       in   1        push w_data onto the stack
//  pop        in   1        discard the top entry
//  w_data     in   WIDTH    data to push
//  clr_err    in   1        clear the sticky overflow and underflow flags
//  tos        out  WIDTH    top entry, mem[sp-1]; 0 when empty
//  nos        out  WIDTH    second entry, mem[sp-2]; 0 when sp < 2
//  sp         out  AW+1     current depth, 0..DEPTH
//  empty      out  1        sp == 0
//  full       out  1        sp == DEPTH
//  overflow   out  1        sticky: a push was attempted while full
//  underflow  out  1        sticky: a pop was attempted while empty
// BEHAVIOUR
//  - Reset, sampled at negedge clk with reset=1:
//    - sp=0, overflow=0, underflow=0, so tos=0, nos=0, empty=1, full=0.
//    - Memory contents are not cleared.
//  - reset has priority over every other input.
//  - tos, nos, empty and full are combinational decodes of the registered sp and mem.
//    They are valid after the falling edge that updates the state, so operands are
//    stable for the next rising-edge consumer.
//  - Operations, all evaluated at negedge clk:
//    - push only, not full: mem[sp] <= w_data; sp <= sp+1.
//    - push only, full: no state change; overflow <= 1.
//    - pop only, sp > 0: sp <= sp-1; the mem entry is left stale.
//    - pop only, empty: no state change; underflow <= 1.
//    - push and pop, sp > 0: replace top, mem[sp-1] <= w_data; sp unchanged.
//      This is not an overflow, even when full.
//    - push and pop, empty: no state change; underflow <= 1.
//    - neither: hold all state.
//  - Error flags:
//    - clr_err=1 clears both flags in the same edge.
//    - If an error event occurs in that same edge, the flag is set; set wins over clr_err.
//    - Flags stay set until clr_err or reset.
//  - Depth accounting:
//    - sp never wraps; it saturates at 0 and at DEPTH.
//    - Writes never index outside 0..DEPTH-1.
//  - Latency: one falling edge from request to the updated tos/sp. There is no handshake;
//    the controller must check full/empty to avoid the error flags.
//  - Reset mid-sequence: a pending push or pop in the reset cycle is dropped.
// TESTING
//  - Reset, then push 0x1111, 0x2222 on consecutive edges -> sp=2, tos=0x2222,
//    nos=0x1111, empty=0.
//  - Push 16 words 0x0000..0x000F -> full=1, tos=0x000F.
//    A 17th push of 0xBEEF -> overflow=1, sp=16, tos=0x000F.
//  - From empty, pop -> underflow=1, sp=0, tos=0.
//    Then clr_err -> underflow=0. Then clr_err+pop in the same edge -> underflow=1.
//  - Stack [0x1111,0x2222], push+pop with w_data=0x3333 -> sp=2, tos=0x3333,
//    nos=0x1111. The same operation on a full stack -> overflow stays 0.
//  - Push 0xAAAA, then reset=1 together with push 0xBBBB -> sp=0, tos=0, flags 0.
//    The next push of 0xCCCC -> tos=0xCCCC, sp=1.
//  - Pop a 3-deep stack down to 0 -> tos/nos/empty track at each falling edge:
//    nos=0 at sp=1, empty=1 at sp=0.

Source files
------------

// File: rtl/stack_unit.sv
// Hardware data stack for the stack-processor datapath: DEPTH x WIDTH storage with
// combinational top/next-of-stack taps, depth tracking and sticky error flags.
module stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] w_data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [AW:0]      sp,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      sp_q;
  logic             overflow_q;
  logic             underflow_q;

  logic [AW-1:0] top_idx;
  logic [AW-1:0] nos_idx;
  logic          push_only;
  logic          pop_only;
  logic          replace;
  logic          do_push;
  logic          do_pop;
  logic          do_replace;
  logic          overflow_evt;
  logic          underflow_evt;

  always_comb begin
    empty = (sp_q == '0);
    full  = (sp_q == (AW+1)'(DEPTH));
    // Low-bit arithmetic wraps modulo DEPTH, so a full stack still indexes DEPTH-1.
    top_idx = sp_q[AW-1:0] - AW'(1);
    nos_idx = sp_q[AW-1:0] - AW'(2);

    push_only = push & ~pop;
    pop_only  = pop & ~push;
    replace   = push & pop;

    do_push    = push_only & ~full;
    do_pop     = pop_only & ~empty;
    do_replace = replace & ~empty;

    overflow_evt  = push_only & full;
    underflow_evt = pop & empty;

    tos = empty ? '0 : mem[top_idx];
    nos = (sp_q < (AW+1)'(2)) ? '0 : mem[nos_idx];

    sp        = sp_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        sp_q <= sp_q + (AW+1)'(1);
      end else if (do_pop) begin
        sp_q <= sp_q - (AW+1)'(1);
      end
      // A new error event in the same edge beats clr_err.
      overflow_q  <= overflow_evt  | (overflow_q  & ~clr_err);
      underflow_q <= underflow_evt | (underflow_q & ~clr_err);
    end
  end

  // Storage is never cleared; entries above sp are simply stale.
  always_ff @(negedge clk) begin
    if (!reset) begin
      if (do_push) begin
        mem[sp_q[AW-1:0]] <= w_data;
      end else if (do_replace) begin
        mem[top_idx] <= w_data;
      end
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios plus randomized traffic
// compared against a queue-based model of the stack.
module tb_stack_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] w_data;
  logic             clr_err;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [AW:0]      sp;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int total;
  int bad;

  logic [WIDTH-1:0] model_q [$];
  logic             model_ovf;
  logic             model_unf;

  logic [40:0] obs;
  assign obs = {tos, nos, sp, empty, full, overflow, underflow};

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .w_data    (w_data),
    .clr_err   (clr_err),
    .tos       (tos),
    .nos       (nos),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [40:0] exp_vec();
    int n;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] s;
    n = model_q.size();
    t = (n >= 1) ? model_q[n-1] : '0;
    s = (n >= 2) ? model_q[n-2] : '0;
    return {t, s, 5'(n), (n == 0), (n == DEPTH), model_ovf, model_unf};
  endfunction

  function automatic void model_apply(input logic p, input logic q, input logic [WIDTH-1:0] d,
                                      input logic c, input logic r);
    logic ovf_e;
    logic unf_e;
    int   n;
    if (r) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
      return;
    end
    n     = model_q.size();
    ovf_e = p && !q && (n == DEPTH);
    unf_e = q && (n == 0);
    if (p && !q && n < DEPTH)      model_q.push_back(d);
    else if (q && !p && n > 0)     void'(model_q.pop_back());
    else if (p && q && n > 0)      model_q[n-1] = d;
    if (c) begin
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end
    if (ovf_e) model_ovf = 1'b1;
    if (unf_e) model_unf = 1'b1;
  endfunction

  // One falling edge with the given request; outputs are settled when it returns.
  task automatic applyStimulus(input logic p, input logic q, input logic [WIDTH-1:0] d,
                               input logic c, input logic r);
    push    = p;
    pop     = q;
    w_data  = d;
    clr_err = c;
    reset   = r;
    model_apply(p, q, d, c, r);
    @(negedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL reset_state: got %h expected %h", obs, exp_vec());
    end
    total++;
    if ({sp, empty, full, tos, nos} !== {5'd0, 1'b1, 1'b0, 16'h0, 16'h0}) begin
      bad++;
      $display("[TB] FAIL reset_const: got sp=%0d empty=%b full=%b tos=%h nos=%h",
               sp, empty, full, tos, nos);
    end
  endtask

  task automatic test_push_pair();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);
    total++;
    if ({sp, tos, nos, empty} !== {5'd2, 16'h2222, 16'h1111, 1'b0}) begin
      bad++;
      $display("[TB] FAIL push_pair: got sp=%0d tos=%h nos=%h empty=%b", sp, tos, nos, empty);
    end
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL push_pair_model: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_fill_overflow();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL fill_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    total++;
    if ({full, tos, overflow} !== {1'b1, 16'h000F, 1'b0}) begin
      bad++;
      $display("[TB] FAIL fill_full: got full=%b tos=%h ovf=%b", full, tos, overflow);
    end
    applyStimulus(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    total++;
    if ({overflow, sp, tos, full} !== {1'b1, 5'd16, 16'h000F, 1'b1}) begin
      bad++;
      $display("[TB] FAIL overflow_push: got ovf=%b sp=%0d tos=%h full=%b",
               overflow, sp, tos, full);
    end
  endtask

  task automatic test_underflow_clr();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
    total++;
    if ({underflow, sp, tos} !== {1'b1, 5'd0, 16'h0}) begin
      bad++;
      $display("[TB] FAIL underflow_pop: got unf=%b sp=%0d tos=%h", underflow, sp, tos);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    total++;
    if (underflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clr_err: got unf=%b expected 0", underflow);
    end
    applyStimulus(1'b0, 1'b1, '0, 1'b1, 1'b0);
    total++;
    if (underflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL set_beats_clr: got unf=%b expected 1", underflow);
    end
    applyStimulus(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0);
    total++;
    if ({underflow, sp, overflow} !== {1'b1, 5'd0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL pushpop_empty: got unf=%b sp=%0d ovf=%b", underflow, sp, overflow);
    end
  endtask

  task automatic test_replace();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h3333, 1'b0, 1'b0);
    total++;
    if ({sp, tos, nos} !== {5'd2, 16'h3333, 16'h1111}) begin
      bad++;
      $display("[TB] FAIL replace: got sp=%0d tos=%h nos=%h", sp, tos, nos);
    end
    for (int i = 0; i < DEPTH - 2; i++) applyStimulus(1'b1, 1'b0, 16'h4000 + 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h7777, 1'b0, 1'b0);
    total++;
    if ({overflow, sp, tos, nos} !== {1'b0, 5'd16, 16'h7777, 16'h400C}) begin
      bad++;
      $display("[TB] FAIL replace_full: got ovf=%b sp=%0d tos=%h nos=%h", overflow, sp, tos, nos);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hBBBB, 1'b0, 1'b1);
    total++;
    if ({sp, tos, overflow, underflow, empty} !== {5'd0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset_mid: got sp=%0d tos=%h ovf=%b unf=%b", sp, tos, overflow, underflow);
    end
    applyStimulus(1'b1, 1'b0, 16'hCCCC, 1'b0, 1'b0);
    total++;
    if ({tos, sp, nos} !== {16'hCCCC, 5'd1, 16'h0}) begin
      bad++;
      $display("[TB] FAIL after_reset_push: got tos=%h sp=%0d nos=%h", tos, sp, nos);
    end
  endtask

  task automatic test_pop_down();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'hA001, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hA002, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hA003, 1'b0, 1'b0);
    for (int i = 2; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL pop_down_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    total++;
    if ({empty, sp, tos, nos, underflow} !== {1'b1, 5'd0, 16'h0, 16'h0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL pop_down_end: got empty=%b sp=%0d tos=%h nos=%h unf=%b",
               empty, sp, tos, nos, underflow);
    end
  endtask

  // Phases alternate between push-heavy and pop-heavy so both bounds are exercised.
  task automatic test_random();
    int bias;
    logic p, q, c, r;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      bias = ((i / 60) % 2 == 0) ? 75 : 25;
      p = ($urandom_range(0, 99) < bias);
      q = ($urandom_range(0, 99) >= bias);
      c = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 149) == 0);
      applyStimulus(p, q, 16'($urandom), c, r);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    model_ovf = 1'b0;
    model_unf = 1'b0;
    reset     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    w_data    = '0;
    clr_err   = 1'b0;
    @(posedge clk);
    test_reset();
    test_push_pair();
    test_fill_overflow();
    test_underflow_clr();
    test_replace();
    test_reset_mid();
    test_pop_down();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
